mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter for the 5-stage pipeline. It shares one unified instruction/data memory port between the fetch stage (instruction reads) and the memory stage (full-word lw/sw). It sequences each transaction with a small FSM and gives data accesses priority, with a starvation guard for fetch. It also drops fetch responses invalidated by jal/branch flushes, and produces the stall terms consumed by the hazard unit.

## Interface
- STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting; the next grant then goes to fetch (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request; held with if_addr until if_ready
- if_addr  in  32  fetch word address (pc)
- if_kill  in  1  jal_flush | branch_flush; discards any in-flight fetch
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data word address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle pulse: access complete
- d_rdata  out  32  load data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, may assert in the first cycle mem_req is high
- if_stall  out  1  combinational: if_req & ~if_ready
- d_stall  out  1  combinational: d_req & ~d_ready

## Operation
- States: IDLE, FETCH, DATA, RESP. All outputs except if_stall/d_stall are registered.
- IDLE: requests are sampled only here.
  - d_req and no starvation: go to DATA; latch d_we/d_addr/d_wdata onto mem_*; set mem_req=1.
  - else if_req: go to FETCH; set mem_we=0, mem_addr=if_addr, mem_req=1.
  - Starvation: d_req & if_req & streak==STARVE_LIMIT grants fetch.
- streak counter:
  - A data grant with if_req high increments it (saturating at STARVE_LIMIT).
  - A data grant with if_req low clears it.
  - A fetch grant clears it.
- FETCH/DATA: hold mem_* stable until mem_ack. On mem_ack go to RESP, clear mem_req and mem_we, and register the response:
  - FETCH: if_rdata ← mem_rdata; if_ready=1 unless the kill flag is set.
  - DATA load: d_rdata ← mem_rdata. DATA store: d_rdata unchanged. d_ready=1 in both cases.
- Kill flag:
  - Set by if_kill in FETCH, or by if_kill in the same cycle as mem_ack in FETCH.
  - A killed fetch completes on the bus, but if_ready stays 0 and if_rdata is not updated.
  - Flag clears on leaving RESP.
  - if_kill in IDLE, DATA or RESP has no effect; the fetch stage re-presents if_req with the new pc.
- RESP: lasts one cycle; ready pulses are high here; then return to IDLE. Requesters change or drop their request after seeing ready.
- Data always completes; if_kill never affects d_*.

## Timing
- Reset values: state IDLE; streak 0; kill 0; mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0; if_ready 0, d_ready 0; if_rdata 32'h00000013 (nop); d_rdata 0.
- rst mid-transaction: mem_req drops immediately, with no completion pulse. Memory must tolerate an abandoned request.
- Latency with a zero-wait memory (request seen in IDLE at cycle T):
  - T+1: mem_req high; mem_ack arrives.
  - T+2: RESP, ready pulse.
  - T+3: IDLE.
  - Peak throughput is one access per 3 cycles. Each wait cycle on mem_ack adds 1.
- mem_ack outside FETCH/DATA is ignored.
- if_ready and d_ready are never high together. Each is high for exactly one cycle per transaction.
- Simultaneous d_req & if_req in IDLE with streak<STARVE_LIMIT: data wins. The fetch stays pending with if_stall=1.

## Test plan
- Reset: assert rst mid-DATA with mem_req=1 → mem_req=0 the same cycle; if_rdata=0x00000013; all ready=0; next grant starts from IDLE.
- Zero-wait fetch: if_req with if_addr=0x100 at T, mem_ack at T+1 with mem_rdata=0x00500093 → mem_addr=0x100 at T+1; if_ready=1 and if_rdata=0x00500093 at T+2; IDLE at T+3.
- Load and store: store d_addr=0x40, d_wdata=0xDEADBEEF, then load 0x40 with mem_rdata=0xDEADBEEF, 2 wait cycles each → mem_we=1 only on the store; d_ready at ack+1; d_rdata=0xDEADBEEF only after the load.
- Priority and starvation: d_req held continuously, if_req high, STARVE_LIMIT=4 → grants DATA×4, then FETCH, then DATA resumes; if_stall=1 until that if_ready.
- Flush: if_kill pulses while FETCH waits for mem_ack (3 wait cycles) → transaction completes on the bus; no if_ready; if_rdata unchanged. A following fetch at a new address returns normally.
- Kill during data: if_kill during DATA → d_ready still pulses; kill flag stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory-port signals of the memory arbiter.
// slave is the arbiter's view; master is the view of the pipeline/memory around it.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_ready, if_rdata, if_stall,
    output d_ready, d_rdata, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_ready, if_rdata, if_stall,
    input  d_ready, d_rdata, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data accesses.
// Data has priority; a streak counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          kill;
  logic          starving;

  assign starving     = bus.d_req & bus.if_req & (streak == LIMIT);
  assign bus.if_stall = bus.if_req & ~bus.if_ready;
  assign bus.d_stall  = bus.d_req & ~bus.d_ready;

  // Transaction sequencer; requests are only sampled in IDLE, every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      streak        <= '0;
      kill          <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.if_rdata  <= 32'h00000013;
      bus.d_rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req && !starving) begin
            state         <= DATA;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            if (!bus.if_req)
              streak <= '0;
            else if (streak != LIMIT)
              streak <= streak + SW'(1);
          end else if (bus.if_req) begin
            state        <= FETCH;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.if_addr;
            streak       <= '0;
          end
        end

        // A kill arriving with or before the ack still lets the bus cycle finish,
        // but the instruction is discarded.
        FETCH: begin
          if (bus.if_kill)
            kill <= 1'b1;
          if (bus.mem_ack) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (!(kill || bus.if_kill)) begin
              bus.if_ready <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end

        DATA: begin
          if (bus.mem_ack) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.d_ready <= 1'b1;
            if (!bus.mem_we)
              bus.d_rdata <= bus.mem_rdata;
          end
        end

        RESP: begin
          state        <= IDLE;
          bus.if_ready <= 1'b0;
          bus.d_ready  <= 1'b0;
          kill         <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
